// File: rtl/addr_gen_pool_strided.sv
// Strided pooling-window address generator: walks C channels of an HxW ifmap with a KxL
// window at stride SHxSW and emits one word address per kernel element over valid/ready.
// Optional feature macro: ADDR_BASE_EN (adds a BASE input offset latched with START).
module addr_gen_pool_strided #(
    parameter int ADDR_WIDTH    = 16,
    parameter int HEIGHT_WIDTH  = 7,
    parameter int KERSIZE_WIDTH = 5,
    parameter int STRIDE_WIDTH  = 3,
    parameter int CH_WIDTH      = 6
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [CH_WIDTH-1:0]      C,
    input  logic [HEIGHT_WIDTH-1:0]  H,
    input  logic [HEIGHT_WIDTH-1:0]  W,
    input  logic [KERSIZE_WIDTH-1:0] K,
    input  logic [KERSIZE_WIDTH-1:0] L,
    input  logic [STRIDE_WIDTH-1:0]  SH,
    input  logic [STRIDE_WIDTH-1:0]  SW,
`ifdef ADDR_BASE_EN
    input  logic [ADDR_WIDTH-1:0]    BASE,
`endif
    input  logic                     BIAS_READY,
    output logic                     BIAS_VALID,
    output logic [ADDR_WIDTH-1:0]    BIAS,
    output logic [CH_WIDTH-1:0]      BIAS_CH,
    output logic                     BIAS_PACK,
    output logic                     BIAS_LAST,
    output logic                     BUSY,
    output logic                     ERR
);

    localparam int DW = HEIGHT_WIDTH + KERSIZE_WIDTH + STRIDE_WIDTH;
    localparam int MW = CH_WIDTH + 2 * HEIGHT_WIDTH + STRIDE_WIDTH;
    localparam logic [63:0] ADDR_SPAN = 64'd1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GEN, S_DONE} state_t;

    state_t                   r_state;
    logic [CH_WIDTH-1:0]      r_cfg_c;
    logic [HEIGHT_WIDTH-1:0]  r_cfg_h, r_cfg_w;
    logic [KERSIZE_WIDTH-1:0] r_cfg_k, r_cfg_l;
    logic [STRIDE_WIDTH-1:0]  r_cfg_sh, r_cfg_sw;
    logic [ADDR_WIDTH-1:0]    r_hw, r_shw;

    // Walk state: (r_row, r_col) is the window origin, r_line_base = (row + i) * W.
    logic [CH_WIDTH-1:0]      r_c;
    logic [KERSIZE_WIDTH-1:0] r_i, r_j;
    logic [HEIGHT_WIDTH-1:0]  r_row, r_col;
    logic [ADDR_WIDTH-1:0]    r_ch_base, r_win_base, r_line_base;

    logic                     r_valid, r_pack, r_last, r_busy, r_err;
    logic [ADDR_WIDTH-1:0]    r_bias;
    logic [CH_WIDTH-1:0]      r_bias_ch;

    logic [ADDR_WIDTH-1:0]    w_base;
    logic [MW-1:0]            w_chw, w_hw, w_shw;
    logic [DW-1:0]            w_h, w_w, w_k, w_l, w_sh, w_sw, w_row, w_col;
    logic                     w_cfg_bad;
    logic                     w_last_j, w_last_i, w_last_col, w_last_row, w_last_c;
    logic                     w_xfer, w_load;
    logic [ADDR_WIDTH-1:0]    w_addr;

`ifdef ADDR_BASE_EN
    logic [ADDR_WIDTH-1:0]    r_base;
    assign w_base = r_base;
`else
    assign w_base = '0;
`endif

    assign w_h   = DW'(r_cfg_h);
    assign w_w   = DW'(r_cfg_w);
    assign w_k   = DW'(r_cfg_k);
    assign w_l   = DW'(r_cfg_l);
    assign w_sh  = DW'(r_cfg_sh);
    assign w_sw  = DW'(r_cfg_sw);
    assign w_row = DW'(r_row);
    assign w_col = DW'(r_col);

    assign w_chw = MW'(r_cfg_c) * MW'(r_cfg_h) * MW'(r_cfg_w);
    assign w_hw  = MW'(r_cfg_h) * MW'(r_cfg_w);
    assign w_shw = MW'(r_cfg_sh) * MW'(r_cfg_w);

    assign w_cfg_bad = (r_cfg_c == '0) || (r_cfg_h == '0) || (r_cfg_w == '0) ||
                       (r_cfg_k == '0) || (r_cfg_l == '0) ||
                       (r_cfg_sh == '0) || (r_cfg_sw == '0) ||
                       (w_k > w_h) || (w_l > w_w) || (64'(w_chw) > ADDR_SPAN);

    // A further window fits only if its far edge stays inside the map.
    assign w_last_j   = (r_j == r_cfg_l - 1'b1);
    assign w_last_i   = (r_i == r_cfg_k - 1'b1);
    assign w_last_col = (w_col + w_sw + w_l > w_w);
    assign w_last_row = (w_row + w_sh + w_k > w_h);
    assign w_last_c   = (r_c == r_cfg_c - 1'b1);

    assign w_addr = w_base + r_ch_base + r_line_base + ADDR_WIDTH'(r_col) + ADDR_WIDTH'(r_j);
    assign w_xfer = r_valid && BIAS_READY;
    assign w_load = !r_valid || BIAS_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_cfg_c     <= '0;
            r_cfg_h     <= '0;
            r_cfg_w     <= '0;
            r_cfg_k     <= '0;
            r_cfg_l     <= '0;
            r_cfg_sh    <= '0;
            r_cfg_sw    <= '0;
            r_hw        <= '0;
            r_shw       <= '0;
            r_c         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_ch_base   <= '0;
            r_win_base  <= '0;
            r_line_base <= '0;
            r_valid     <= 1'b0;
            r_bias      <= '0;
            r_bias_ch   <= '0;
            r_pack      <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef ADDR_BASE_EN
            r_base      <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_cfg_c  <= C;
                        r_cfg_h  <= H;
                        r_cfg_w  <= W;
                        r_cfg_k  <= K;
                        r_cfg_l  <= L;
                        r_cfg_sh <= SH;
                        r_cfg_sw <= SW;
`ifdef ADDR_BASE_EN
                        r_base   <= BASE;
`endif
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (ABORT) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_cfg_bad) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hw        <= ADDR_WIDTH'(w_hw);
                        r_shw       <= ADDR_WIDTH'(w_shw);
                        r_c         <= '0;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_ch_base   <= '0;
                        r_win_base  <= '0;
                        r_line_base <= '0;
                        r_state     <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (ABORT) begin
                        r_valid <= 1'b0;
                        r_pack  <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_xfer && r_last) begin
                        r_valid <= 1'b0;
                        r_pack  <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_load) begin
                        r_valid   <= 1'b1;
                        r_bias    <= w_addr;
                        r_bias_ch <= r_c;
                        r_pack    <= w_last_i && w_last_j;
                        r_last    <= w_last_i && w_last_j && w_last_col && w_last_row && w_last_c;
                        // Odometer advance: j, i, window column, window row, channel.
                        if (!w_last_j) begin
                            r_j <= r_j + 1'b1;
                        end else begin
                            r_j <= '0;
                            if (!w_last_i) begin
                                r_i         <= r_i + 1'b1;
                                r_line_base <= r_line_base + ADDR_WIDTH'(r_cfg_w);
                            end else begin
                                r_i <= '0;
                                if (!w_last_col) begin
                                    r_col       <= r_col + HEIGHT_WIDTH'(r_cfg_sw);
                                    r_line_base <= r_win_base;
                                end else begin
                                    r_col <= '0;
                                    if (!w_last_row) begin
                                        r_row       <= r_row + HEIGHT_WIDTH'(r_cfg_sh);
                                        r_win_base  <= r_win_base + r_shw;
                                        r_line_base <= r_win_base + r_shw;
                                    end else begin
                                        r_row       <= '0;
                                        r_win_base  <= '0;
                                        r_line_base <= '0;
                                        r_c         <= r_c + 1'b1;
                                        r_ch_base   <= r_ch_base + r_hw;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BIAS_VALID = r_valid;
    assign BIAS       = r_bias;
    assign BIAS_CH    = r_bias_ch;
    assign BIAS_PACK  = r_pack;
    assign BIAS_LAST  = r_last;
    assign BUSY       = r_busy;
    assign ERR        = r_err;

endmodule

// File: tb/tb_addr_gen_pool_strided.sv
// Bench for addr_gen_pool_strided: table of configurations plus random passes, each checked
// beat-by-beat against a nested-loop address model; abort and reset handled as sequences.
module tb_addr_gen_pool_strided;

    logic        CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, ABORT = 1'b0, BIAS_READY = 1'b0;
    logic [5:0]  C = '0;
    logic [6:0]  H = '0, W = '0;
    logic [4:0]  K = '0, L = '0;
    logic [2:0]  SH = '0, SW = '0;
    logic        BIAS_VALID, BIAS_PACK, BIAS_LAST, BUSY, ERR;
    logic [15:0] BIAS;
    logic [5:0]  BIAS_CH;
`ifdef ADDR_BASE_EN
    logic [15:0] BASE = '0;
`endif

    addr_gen_pool_strided dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .C(C), .H(H), .W(W), .K(K), .L(L), .SH(SH), .SW(SW),
`ifdef ADDR_BASE_EN
        .BASE(BASE),
`endif
        .BIAS_READY(BIAS_READY), .BIAS_VALID(BIAS_VALID), .BIAS(BIAS), .BIAS_CH(BIAS_CH),
        .BIAS_PACK(BIAS_PACK), .BIAS_LAST(BIAS_LAST), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int c, h, w, k, l, sh, sw;
        bit rdy_rand;
        bit exp_err;
        int exp_beats;
    } vec_t;

    typedef struct {
        int addr;
        int ch;
        bit pack;
        bit last;
    } beat_t;

    int    vectors = 0, miscompares = 0;
    beat_t exp_q[$];
    int    got_addr[$];
    int    base_val = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: spec rules written as plain nested loops over the output grid.
    function automatic bit model(input vec_t v, input int base);
        int oh_n, ow_n;
        longint chw;
        beat_t b;
        exp_q.delete();
        chw = longint'(v.c) * v.h * v.w;
        if (v.c == 0 || v.h == 0 || v.w == 0 || v.k == 0 || v.l == 0 || v.sh == 0 ||
            v.sw == 0 || v.k > v.h || v.l > v.w || chw > 65536)
            return 1'b1;
        oh_n = (v.h - v.k) / v.sh + 1;
        ow_n = (v.w - v.l) / v.sw + 1;
        for (int c = 0; c < v.c; c++)
            for (int oh = 0; oh < oh_n; oh++)
                for (int ow = 0; ow < ow_n; ow++)
                    for (int i = 0; i < v.k; i++)
                        for (int j = 0; j < v.l; j++) begin
                            b.addr = (base + c * v.h * v.w + (oh * v.sh + i) * v.w + ow * v.sw + j) & 16'hFFFF;
                            b.ch   = c;
                            b.pack = (i == v.k - 1) && (j == v.l - 1);
                            b.last = b.pack && (c == v.c - 1) && (oh == oh_n - 1) && (ow == ow_n - 1);
                            exp_q.push_back(b);
                        end
        return 1'b0;
    endfunction

    task automatic start_pass(input vec_t v, input int base);
        @(negedge CLK);
        C = 6'(v.c); H = 7'(v.h); W = 7'(v.w); K = 5'(v.k); L = 5'(v.l);
        SH = 3'(v.sh); SW = 3'(v.sw);
`ifdef ADDR_BASE_EN
        BASE = 16'(base);
`endif
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        // Scramble the live inputs; only the latched copies may matter from here on.
        C = 6'($urandom); H = 7'($urandom); W = 7'($urandom); K = 5'($urandom);
        L = 5'($urandom); SH = 3'($urandom); SW = 3'($urandom);
`ifdef ADDR_BASE_EN
        BASE = 16'($urandom);
`endif
    endtask

    task automatic run_pass(input vec_t v, input int base);
        bit exp_err;
        int exp_n, n_beats, err_cnt, cyc, budget, first_vld, first_x, last_x, vld_on_err;
        bit stalled;
        logic [24:0] held;
        beat_t e;
        exp_err = model(v, base);
        exp_n = exp_q.size();
        got_addr.delete();
        n_beats = 0; err_cnt = 0; cyc = 0; first_vld = -1; first_x = -1; last_x = -1;
        vld_on_err = 0; stalled = 1'b0; held = '0;
        budget = 4 * exp_n + 60;
        start_pass(v, base);
        while (cyc < budget) begin
            if (ERR) err_cnt++;
            if (exp_err && BIAS_VALID) vld_on_err++;
            if (stalled)
                check("stall_hold", 64'({BIAS_VALID, BIAS, BIAS_CH, BIAS_PACK, BIAS_LAST}), 64'(held));
            BIAS_READY = v.rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (BIAS_VALID && first_vld < 0) first_vld = cyc;
            if (BIAS_VALID && BIAS_READY) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(BIAS), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", 64'(BIAS), 64'(e.addr));
                    check("ch_pack_last", 64'({BIAS_CH, BIAS_PACK, BIAS_LAST}),
                          64'({6'(e.ch), e.pack, e.last}));
                end
                got_addr.push_back(int'(BIAS));
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                n_beats++;
            end
            stalled = BIAS_VALID && !BIAS_READY;
            held = {BIAS_VALID, BIAS, BIAS_CH, BIAS_PACK, BIAS_LAST};
            if (!BUSY) break;
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("timeout", 64'(cyc >= budget), 64'(0));
        check("beats_vs_table", 64'(n_beats), 64'(v.exp_beats < 0 ? exp_n : v.exp_beats));
        check("beats_left", 64'(exp_q.size()), 64'(0));
        check("err_pulses", 64'(err_cnt), 64'(exp_err ? 1 : 0));
        check("busy_end", 64'(BUSY), 64'(0));
        if (exp_err) check("valid_on_err", 64'(vld_on_err), 64'(0));
        else begin
            check("latency_ok", 64'(first_vld >= 1 && first_vld <= 4), 64'(1));
            if (!v.rdy_rand) check("no_bubbles", 64'(last_x - first_x + 1), 64'(n_beats));
        end
        @(posedge CLK);
        #1;
        check("err_one_cycle", 64'(ERR), 64'(0));
    endtask

    initial begin
        vec_t tbl[9];
        vec_t rv;
        int case1[16];
        int n;
        tbl = '{
            '{1, 4, 4, 2, 2, 2, 2, 1'b0, 1'b0, 16},
            '{1, 3, 3, 2, 2, 1, 1, 1'b0, 1'b0, 16},
            '{2, 5, 5, 2, 2, 2, 2, 1'b0, 1'b0, 32},
            '{1, 4, 4, 2, 2, 2, 2, 1'b1, 1'b0, 16},
            '{1, 5, 5, 6, 2, 1, 1, 1'b0, 1'b1, 0},
            '{1, 4, 4, 2, 2, 2, 0, 1'b0, 1'b1, 0},
            '{5, 127, 127, 2, 2, 7, 7, 1'b0, 1'b1, 0},
            '{16, 64, 64, 1, 1, 7, 7, 1'b0, 1'b0, 1600},
            '{17, 64, 64, 1, 1, 7, 7, 1'b0, 1'b1, 0}
        };
        case1 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
`ifdef ADDR_BASE_EN
        base_val = 'h100;
`endif

        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 64'({BIAS_VALID, BIAS, BIAS_CH, BIAS_PACK, BIAS_LAST, BUSY, ERR}), 64'(0));
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int t = 0; t < 9; t++) begin
            run_pass(tbl[t], base_val);
            if (t == 0)
                for (int i = 0; i < 16; i++)
                    check("case1_order", 64'(i < got_addr.size() ? got_addr[i] : -1),
                          64'((case1[i] + base_val) & 16'hFFFF));
            if (t == 2) begin
                n = got_addr.size();
                check("ch0_end", 64'(n > 15 ? got_addr[15] : -1), 64'(18 + base_val));
                check("ch1_start", 64'(n > 16 ? got_addr[16] : -1), 64'(25 + base_val));
                check("pass_last", 64'(n > 31 ? got_addr[31] : -1), 64'(43 + base_val));
            end
        end

        // Abort after five beats of case 1.
        BIAS_READY = 1'b1;
        start_pass(tbl[0], base_val);
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            if (BIAS_VALID && BIAS_READY) n++;
            @(posedge CLK);
            #1;
        end
        check("abort_pre_beats", 64'(n), 64'(5));
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        check("abort_state", 64'({BIAS_VALID, BIAS_LAST, BUSY}), 64'(0));
        n = 0;
        repeat (4) begin
            if (BIAS_VALID || BIAS_LAST || BUSY) n++;
            @(posedge CLK);
            #1;
        end
        check("abort_quiet", 64'(n), 64'(0));

        // Asynchronous reset in the middle of a pass.
        start_pass(tbl[2], base_val);
        repeat (6) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        #1;
        check("reset_mid", 64'({BIAS_VALID, BIAS, BIAS_CH, BIAS_PACK, BIAS_LAST, BUSY, ERR}), 64'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        run_pass(tbl[0], base_val);

        for (int r = 0; r < 25; r++) begin
            rv.c = $urandom_range(1, 2);
            rv.h = $urandom_range(1, 6);
            rv.w = $urandom_range(1, 6);
            rv.k = $urandom_range(1, rv.h);
            rv.l = $urandom_range(1, rv.w);
            rv.sh = $urandom_range(1, 3);
            rv.sw = $urandom_range(1, 3);
            case ($urandom_range(0, 11))
                0: rv.c = 0;
                1: rv.sh = 0;
                2: rv.k = rv.h + 1;
                3: rv.l = 0;
                default: ;
            endcase
            rv.rdy_rand = 1'($urandom_range(0, 1));
            rv.exp_err = 1'b0;
            rv.exp_beats = -1;
`ifdef ADDR_BASE_EN
            base_val = int'($urandom_range(0, 65535));
`endif
            run_pass(rv, base_val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
